// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the CPU controller's memory command interface.
//   Each accepted command (read, write or illegal) is held for WAIT_CYCLES
//   cycles and then completed with a one-cycle mem_ready pulse. Commands are
//   serviced from an internal RAM (mem_addr[8]==0) or from two memory-mapped
//   I/O registers: a read-only switch port and a write-only LED register.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous active-low reset
//   mem_cmd    : 2'b00 none, 2'b01 read, 2'b10 write, 2'b11 illegal
//   mem_addr   : word address
//   write_data : data for write commands
//   read_data  : registered read result, holds between reads
//   mem_ready  : one-cycle completion pulse
//   bus_err    : one-cycle pulse with mem_ready for unmapped/illegal accesses
//   switches   : asynchronous board switches (synchronised internally)
//   leds       : LED register
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 9,
    parameter int                RAM_DEPTH   = 256,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] LED_ADDR    = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR     = 9'h140
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    output logic              bus_err,
    input  logic [7:0]        switches,
    output logic [7:0]        leds
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    // Wait counter is 3 bits wide: WAIT_CYCLES is limited to 0..7.
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Resolved operation for a (command, address) pair.
    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_RAM_RD = 3'd1,
        OP_RAM_WR = 3'd2,
        OP_SW_RD  = 3'd3,
        OP_LED_WR = 3'd4,
        OP_ERR    = 3'd5
    } op_t;

    // Address/command decode. Anything in the upper half that is not the
    // matching MMIO register for the direction is an error, as is cmd 2'b11.
    function automatic op_t decode_op(input logic [1:0] cmd,
                                      input logic [ADDR_W-1:0] addr);
        op_t op;
        op = OP_NONE;
        case (cmd)
            CMD_NONE: begin
                op = OP_NONE;
            end
            CMD_READ: begin
                if (addr[ADDR_W-1] == 1'b0) begin
                    op = OP_RAM_RD;
                end else if (addr == SW_ADDR) begin
                    op = OP_SW_RD;
                end else begin
                    op = OP_ERR;
                end
            end
            CMD_WRITE: begin
                if (addr[ADDR_W-1] == 1'b0) begin
                    op = OP_RAM_WR;
                end else if (addr == LED_ADDR) begin
                    op = OP_LED_WR;
                end else begin
                    op = OP_ERR;
                end
            end
            default: begin
                op = OP_ERR;
            end
        endcase
        return op;
    endfunction

    state_t              state_r;
    logic [2:0]          cnt_r;
    logic [1:0]          cmd_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   read_data_r;
    logic                mem_ready_r;
    logic                bus_err_r;
    logic [7:0]          leds_r;
    logic [7:0]          sw_meta_r;
    logic [7:0]          sw_sync_r;
    logic [DATA_W-1:0]   ram_r [RAM_DEPTH];

    logic                complete_s;
    logic [1:0]          op_cmd_s;
    logic [ADDR_W-1:0]   op_addr_s;
    logic [DATA_W-1:0]   op_wdata_s;
    op_t                 op_s;
    logic                ram_we_s;

    // Completion decode: identifies the edge that enters DONE and selects the
    // command fields to act on. With zero wait states that edge is the
    // acceptance edge itself, so the live inputs are used instead of the
    // captured copies.
    always_comb begin
        complete_s = 1'b0;
        op_cmd_s   = cmd_r;
        op_addr_s  = addr_r;
        op_wdata_s = wdata_r;
        if (!reset) begin
            complete_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if ((WAIT_LOAD == 3'd0) && (mem_cmd != CMD_NONE)) begin
                        complete_s = 1'b1;
                        op_cmd_s   = mem_cmd;
                        op_addr_s  = mem_addr;
                        op_wdata_s = write_data;
                    end else begin
                        complete_s = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 3'd1) begin
                        complete_s = 1'b1;
                    end else begin
                        complete_s = 1'b0;
                    end
                end
                ST_DONE: begin
                    complete_s = 1'b0;
                end
                default: begin
                    complete_s = 1'b0;
                end
            endcase
        end
        if (complete_s) begin
            op_s = decode_op(op_cmd_s, op_addr_s);
        end else begin
            op_s = OP_NONE;
        end
        ram_we_s = (op_s == OP_RAM_WR);
    end

    // RAM write port; deliberately has no reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[op_addr_s[RAM_AW-1:0]] <= op_wdata_s;
        end
    end

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_r <= 8'h00;
            sw_sync_r <= 8'h00;
        end else begin
            sw_meta_r <= switches;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Transaction FSM with registered completion outputs and MMIO/read effects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            cmd_r       <= CMD_NONE;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            read_data_r <= {DATA_W{1'b0}};
            mem_ready_r <= 1'b0;
            bus_err_r   <= 1'b0;
            leds_r      <= 8'h00;
        end else begin
            mem_ready_r <= 1'b0;
            bus_err_r   <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (mem_cmd != CMD_NONE) begin
                        cmd_r   <= mem_cmd;
                        addr_r  <= mem_addr;
                        wdata_r <= write_data;
                        if (WAIT_LOAD == 3'd0) begin
                            state_r <= ST_DONE;
                        end else begin
                            cnt_r   <= WAIT_LOAD;
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 3'd1;
                    if (cnt_r == 3'd1) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    // Single completion cycle; inputs are not sampled here.
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            if (complete_s) begin
                mem_ready_r <= 1'b1;
                case (op_s)
                    OP_RAM_RD: begin
                        read_data_r <= ram_r[op_addr_s[RAM_AW-1:0]];
                    end
                    OP_SW_RD: begin
                        read_data_r <= {{(DATA_W-8){1'b0}}, sw_sync_r};
                    end
                    OP_LED_WR: begin
                        leds_r <= op_wdata_s[7:0];
                    end
                    OP_ERR: begin
                        bus_err_r <= 1'b1;
                        // Unmapped reads return zero; illegal commands and
                        // unmapped writes leave read_data untouched.
                        if (op_cmd_s == CMD_READ) begin
                            read_data_r <= {DATA_W{1'b0}};
                        end else begin
                            read_data_r <= read_data_r;
                        end
                    end
                    default: begin
                        read_data_r <= read_data_r;
                    end
                endcase
            end
        end
    end

    assign read_data = read_data_r;
    assign mem_ready = mem_ready_r;
    assign bus_err   = bus_err_r;
    assign leds      = leds_r;

    mem_responder_checker u_checker (
        .clk       (clk),
        .reset     (reset),
        .mem_ready (mem_ready_r),
        .bus_err   (bus_err_r)
    );

endmodule

// -----------------------------------------------------------------------------
// mem_responder_checker
//   Protocol properties of the completion handshake.
//
// Ports
//   clk, reset : clock and asynchronous active-low reset
//   mem_ready  : completion pulse from the responder
//   bus_err    : error pulse from the responder
// -----------------------------------------------------------------------------
module mem_responder_checker (
    input logic clk,
    input logic reset,
    input logic mem_ready,
    input logic bus_err
);

    // An error is only ever reported together with a completion.
    a_err_with_ready: assert property (
        @(posedge clk) disable iff (!reset) bus_err |-> mem_ready
    );

    // Completion is a single-cycle pulse.
    a_ready_single: assert property (
        @(posedge clk) disable iff (!reset) mem_ready |=> !mem_ready
    );

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU controller's memory command interface.
- Accepts M_NONE/M_READ/M_WRITE commands with a 9-bit address and 16-bit write data.
- Services each command from an internal 256x16 RAM or two memory-mapped I/O locations (switches, LEDs).
- Inserts programmable wait states and signals completion with a one-cycle mem_ready pulse. Sits between the controller/datapath and the board I/O.

Parameters:
- DATA_W, 16, data bus width.
- ADDR_W, 9, address bus width.
- RAM_DEPTH, 256, RAM words; RAM occupies addresses with mem_addr[8]==0.
- WAIT_CYCLES, 1, wait cycles inserted between acceptance and completion; legal range 0..7.
- LED_ADDR, 9'h100, write-only LED register address.
- SW_ADDR, 9'h140, read-only switch register address.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_cmd  input  2  2'b00 M_NONE, 2'b01 M_READ, 2'b10 M_WRITE, 2'b11 illegal.
- mem_addr  input  9  word address.
- write_data  input  16  data for M_WRITE.
- read_data  output  16  registered read result.
- mem_ready  output  1  one-cycle completion pulse.
- bus_err  output  1  one-cycle pulse, coincident with mem_ready, for unmapped access or illegal command.
- switches  input  8  asynchronous board switches.
- leds  output  8  LED register.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, read_data=16'h0000, mem_ready=0, bus_err=0, leds=8'h00, wait counter=0, switch synchronizer=0.
  - RAM contents are not cleared.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On a rising edge with mem_cmd!=M_NONE, capture cmd, addr and write_data into internal registers.
  - If WAIT_CYCLES==0, next state is DONE. Otherwise load counter=WAIT_CYCLES and go to WAIT.
  - mem_cmd==M_NONE: stay in IDLE.
- WAIT:
  - Decrement the counter each cycle. When counter==1, next state is DONE.
  - Input changes are ignored; only captured values are used.
- DONE (exactly one cycle):
  - mem_ready=1.
  - Always goes to IDLE next. No command is accepted while in DONE.
- Latency: the command is sampled at edge N; mem_ready is high during cycle N+WAIT_CYCLES+1.
- Minimum back-to-back period: WAIT_CYCLES+2 cycles.
- A command still held in IDLE after mem_ready is accepted as a new transaction. The requestor must drop to M_NONE or present the next command.
- Operations take effect on the edge that enters DONE, so results are visible while mem_ready is high:
  - READ, RAM hit: read_data <= RAM[addr[7:0]].
  - READ at SW_ADDR: read_data <= {8'h00, switches_sync}.
  - WRITE, RAM hit: RAM[addr[7:0]] <= captured write_data.
  - WRITE at LED_ADDR: leds <= captured write_data[7:0].
  - READ at LED_ADDR, WRITE at SW_ADDR, or any other addr[8]==1 address: read returns 16'h0000 and a write is dropped; bus_err=1.
  - Illegal command (2'b11): accepted like a normal command with the same latency. No RAM/LED change, read_data unchanged, bus_err=1.
- read_data holds its value between reads. Writes never modify read_data.
- switches pass through a 2-flop synchronizer before use.
- Reset asserted mid-transaction: return to IDLE immediately. The pending write is aborted (RAM and leds unchanged from pre-transaction values). No mem_ready is produced.
- Reset deasserts asynchronously to the clock. The first command can be accepted at the first rising edge with reset==1.

Test Plan:
- WAIT_CYCLES=1: WRITE addr 9'h005 data 16'hABCD, then READ 9'h005 → mem_ready at cycle 2 after each acceptance; read_data=16'hABCD during the second mem_ready; bus_err=0.
- WAIT_CYCLES=0: READ held continuously at 9'h000 after writing 16'h1234 → mem_ready every 2nd cycle with read_data=16'h1234; confirms DONE does not accept.
- MMIO: switches=8'h5A, wait 3 cycles, READ 9'h140 → read_data=16'h005A. WRITE 9'h100 data 16'hFF3C → leds=8'h3C, RAM[0] unchanged.
- Errors: READ 9'h1FF → read_data=16'h0000 and bus_err=1 with mem_ready. mem_cmd=2'b11 → bus_err=1, read_data retains its previous value.
- WAIT_CYCLES=3: change mem_addr/write_data during WAIT → operation uses the captured values; mem_ready in cycle 4 after acceptance.
- Reset mid-WAIT of a WRITE to 9'h010 (old value 16'h0001) → mem_ready never asserts, leds=8'h00, RAM[9'h010]=16'h0001, state IDLE.
